qspi_rx_fifo: RTL and testbench
===============================

# qspi_rx_fifo

Byte FIFO that sits directly downstream of the QSPI flash read controller. It captures every byte the controller presents on `data_qspi2fifo` with a one-cycle `write_req` strobe and buffers it for the consumer (UART/bus bridge) on a registered read port. It also exports `almost_full` so the read sequencer can hold off the next `read_flag` before bytes are lost, and it records overflow and underflow as sticky error flags.

## Interface
- `DEPTH`, 16: entries, power of two, 4..256
- `AF_LEVEL`, DEPTH-4: `almost_full` asserts when count >= AF_LEVEL
- `system_clk`  in  1  single clock for both ports
- `system_reset_n`  in  1  reset, asynchronous, active-low
- `write_req`  in  1  one-cycle strobe from QSPI controller, byte valid
- `data_qspi2fifo`  in  8  byte from QSPI controller, sampled when write_req=1
- `flush`  in  1  synchronous clear of contents and error flags
- `rd_en`  in  1  consumer pops one byte
- `rd_data`  out  8  popped byte, valid when rd_valid=1
- `rd_valid`  out  1  one-cycle pulse, cycle after accepted pop
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH
- `almost_full`  out  1  count >= AF_LEVEL
- `fill_count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: write_req while full and no pop
- `underflow`  out  1  sticky: rd_en while empty

## Operation
- Storage: DEPTH x 8 array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0; count held in a separate counter (no pointer-MSB scheme).
- Push accepted when write_req=1 and (count<DEPTH or pop accepted same cycle); byte written at `wp`, `wp` increments.
- Pop accepted when rd_en=1 and count>0; byte at `rp` registered to rd_data, rd_valid=1 next cycle, `rp` increments.
- Count update: +1 push only, -1 pop only, unchanged for both or neither.
- Full + write_req + rd_en: both accepted, count stays DEPTH, no overflow.
- Full + write_req, no rd_en: byte dropped, pointers unchanged, overflow set.
- Empty + rd_en + write_req: push accepted, pop rejected, underflow set, rd_valid stays 0; the byte is poppable next cycle.
- Empty + rd_en, no write_req: underflow set, rd_valid=0.
- No read-before-write bypass: a byte is never returned in the cycle it is written.
- flush=1: wp, rp, count cleared, overflow/underflow cleared, rd_valid=0; write_req and rd_en in the same cycle are ignored. flush wins over all other events.
- rd_data holds its last value when rd_valid=0.

## Timing
- Reset (async assert, sync-released by top level): wp=rp=0, count=0, rd_data=8'h00, rd_valid=0, empty=1, full=0, almost_full=0, fill_count=0, overflow=0, underflow=0. Array contents are not reset.
- Reset mid-transfer: all in-flight bytes discarded, outputs take reset values immediately.
- Write latency: a byte pushed at edge N is reflected in count/empty after edge N and poppable from cycle N+1.
- Read latency: rd_en sampled at edge N -> rd_data/rd_valid valid after edge N, held one cycle.
- empty, full, almost_full, fill_count are registered/derived from the registered count; no combinational path from write_req or rd_en.
- write_req needs no handshake back: the controller never stalls, so almost_full is the only flow control and is advisory.

## Structure
- Shared package `qspi_pkg`: `QSPI_BYTE_W = 8`, `QSPI_FIFO_DEPTH_DEF = 16`, mode encodings (`QSPI_MODE_STD = 2'b00`, `DUAL = 2'b01`, `QUAD = 2'b10`) used by the controller and this FIFO's bench.
- One sub-module, `qspi_fifo_ram`: simple dual-port, one write port, one registered read port, no reset, inferable as block RAM or LUTRAM.
- Pointers, counter, flags, and flush logic stay in `qspi_rx_fifo`.

## Test plan
- Reset, then push 8'hAA, 8'h55, 8'hBB on three write_req pulses; pop three -> rd_data 8'hAA, 8'h55, 8'hBB on consecutive rd_valid pulses; empty=1 and fill_count=0 after.
- Push 16 bytes 8'h00..8'h0F (DEPTH=16) -> almost_full at count 12, full at 16. A 17th push 8'hFF -> overflow=1, count 16. Pop all -> 8'h00..8'h0F, no 8'hFF.
- Full FIFO with simultaneous write_req (8'h77) and rd_en -> count stays 16, overflow=0. Drain confirms 8'h77 as the last byte.
- Empty FIFO with rd_en and write_req 8'h3C in the same cycle -> underflow=1, rd_valid=0. The next pop returns 8'h3C.
- Wrap-around: push 10 then pop 10, three times, with values 8'h10+i -> order preserved across pointer wrap, count correct throughout.
- Push 5 bytes, assert flush with a concurrent write_req -> count=0, empty=1, flags cleared, concurrent byte discarded. Async reset asserted mid-push -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared constants for the QSPI flash read path: byte width, default FIFO depth
// and the lane-mode encodings used by the controller.
package qspi_pkg;

  localparam int unsigned QSPI_BYTE_W         = 8;
  localparam int unsigned QSPI_FIFO_DEPTH_DEF = 16;

  localparam logic [1:0] QSPI_MODE_STD  = 2'b00;
  localparam logic [1:0] QSPI_MODE_DUAL = 2'b01;
  localparam logic [1:0] QSPI_MODE_QUAD = 2'b10;

  // Occupancy counter width for a FIFO of the given depth.
  function automatic int unsigned qspi_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qspi_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with enable.
// No reset so it maps onto block RAM or LUTRAM.
module qspi_fifo_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read-first: a same-address write in this cycle is not visible here.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/qspi_rx_fifo.sv
// Receive byte FIFO between the QSPI read controller and the consumer, with
// advisory almost_full, registered read port and sticky overflow/underflow flags.
module qspi_rx_fifo
  import qspi_pkg::*;
#(
  parameter int unsigned DEPTH    = QSPI_FIFO_DEPTH_DEF,
  parameter int unsigned AF_LEVEL = DEPTH - 4
) (
  input  logic                   system_clk,
  input  logic                   system_reset_n,
  input  logic                   write_req,
  input  logic [QSPI_BYTE_W-1:0] data_qspi2fifo,
  input  logic                   flush,
  input  logic                   rd_en,
  output logic [QSPI_BYTE_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] fill_count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = qspi_cnt_w(DEPTH);

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);

  logic [AW-1:0]          wp_q, wp_d;
  logic [AW-1:0]          rp_q, rp_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   valid_q, valid_d;
  logic                   primed_q, primed_d;
  logic                   push, pop;
  logic [QSPI_BYTE_W-1:0] ram_rdata;

  always_comb begin
    pop  = rd_en & (count_q != '0) & ~flush;
    push = write_req & ((count_q != DepthCnt) | pop) & ~flush;

    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    valid_d  = 1'b0;
    primed_d = primed_q;

    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (push) begin
        wp_d = wp_q + 1'b1;
      end
      if (pop) begin
        rp_d = rp_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Outside flush, a rejected write can only mean full with no pop.
      ovf_d    = ovf_q | (write_req & ~push);
      udf_d    = udf_q | (rd_en & (count_q == '0));
      valid_d  = pop;
      primed_d = primed_q | pop;
    end
  end

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  qspi_fifo_ram #(
    .Depth (DEPTH),
    .Width (QSPI_BYTE_W)
  ) u_ram (
    .clk_i   (system_clk),
    .we_i    (push),
    .waddr_i (wp_q),
    .wdata_i (data_qspi2fifo),
    .re_i    (pop),
    .raddr_i (rp_q),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; mask it until the first pop since reset.
  assign rd_data     = primed_q ? ram_rdata : '0;
  assign rd_valid    = valid_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DepthCnt);
  assign almost_full = (count_q >= AfCnt);
  assign fill_count  = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Self-checking bench for qspi_rx_fifo: vector table, directed corner cases and
// random traffic against a queue-based reference model.
module tb_qspi_rx_fifo;
  import qspi_pkg::*;

  localparam int unsigned DEPTH = QSPI_FIFO_DEPTH_DEF;
  localparam int unsigned AFL   = DEPTH - 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_req, flush, rd_en;
  logic [7:0] din;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, almost_full, overflow, underflow;
  logic [$clog2(DEPTH):0] fill_count;

  always #5 clk = ~clk;

  qspi_rx_fifo #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AFL)
  ) dut (
    .system_clk     (clk),
    .system_reset_n (rst_n),
    .write_req      (write_req),
    .data_qspi2fifo (din),
    .flush          (flush),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .fill_count     (fill_count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, outputs as plain variables.
  logic [7:0] mq[$];
  logic [7:0] m_data;
  logic       m_valid, m_ovf, m_udf;

  function automatic void model_reset();
    mq.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endfunction

  function automatic void model_step(input logic wr, input logic [7:0] d, input logic fl,
                                     input logic rd);
    bit can_pop, can_push;
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      return;
    end
    can_pop  = rd && (mq.size() > 0);
    can_push = wr && ((mq.size() < DEPTH) || can_pop);
    if (rd && mq.size() == 0) m_udf = 1'b1;
    if (wr && !can_push) m_ovf = 1'b1;
    m_valid = can_pop;
    if (can_pop) m_data = mq.pop_front();
    if (can_push) mq.push_back(d);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_valid"},    int'(rd_valid),    int'(m_valid));
    chk({tag, ".rd_data"},     int'(rd_data),     int'(m_data));
    chk({tag, ".fill_count"},  int'(fill_count),  n);
    chk({tag, ".empty"},       int'(empty),       int'(n == 0));
    chk({tag, ".full"},        int'(full),        int'(n == DEPTH));
    chk({tag, ".almost_full"}, int'(almost_full), int'(n >= AFL));
    chk({tag, ".overflow"},    int'(overflow),    int'(m_ovf));
    chk({tag, ".underflow"},   int'(underflow),   int'(m_udf));
  endtask

  // Drive one cycle of inputs, advance the model, check just after the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic fl, input logic rd,
                      input string tag);
    write_req = wr;
    din       = d;
    flush     = fl;
    rd_en     = rd;
    @(posedge clk);
    model_step(wr, d, fl, rd);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       rd;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_empty;
    int         e_cnt;
    logic       e_udf;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0};
    vt[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0};
    vt[2] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 2, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 0, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hBB, 1'b1, 0, 1'b0};
    vt[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hBB, 1'b0, 1, 1'b1};
    vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 1'b1};
    vt[9] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 1'b0};

    rst_n = 1'b0; write_req = 1'b0; din = 8'h00; flush = 1'b0; rd_en = 1'b0;
    model_reset();
    #12;
    chk("reset.rd_data", int'(rd_data), 0);
    chk("reset.rd_valid", int'(rd_valid), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full", int'(full), 0);
    chk("reset.almost_full", int'(almost_full), 0);
    chk("reset.fill_count", int'(fill_count), 0);
    chk("reset.overflow", int'(overflow), 0);
    chk("reset.underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: basic order, empty pop + push collision, flush with concurrent traffic.
    for (int i = 0; i < 10; i++) begin
      write_req = vt[i].wr; din = vt[i].d; flush = vt[i].fl; rd_en = vt[i].rd;
      @(posedge clk);
      model_step(vt[i].wr, vt[i].d, vt[i].fl, vt[i].rd);
      #1;
      chk($sformatf("vec%0d.rd_valid", i), int'(rd_valid), int'(vt[i].e_valid));
      chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vt[i].e_data));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vt[i].e_empty));
      chk($sformatf("vec%0d.fill_count", i), int'(fill_count), vt[i].e_cnt);
      chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(vt[i].e_udf));
    end

    // Fill to full, watching the almost_full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      chk("fill.af_level", int'(almost_full), int'(i + 1 >= AFL));
    end
    chk("fill.full", int'(full), 1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, "overflow_push");
    chk("overflow.set", int'(overflow), 1);
    chk("overflow.count", int'(fill_count), DEPTH);
    step(1'b0, 8'h00, 1'b1, 1'b0, "flush_ovf");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "refill");
    step(1'b1, 8'h77, 1'b0, 1'b1, "full_push_pop");
    chk("full_push_pop.count", int'(fill_count), DEPTH);
    chk("full_push_pop.ovf", int'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "drain");
    chk("drain.last", int'(rd_data), 8'h77);

    // Wrap-around: three rounds of 10 in, 10 out.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "wrap_push");
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 8'h00, 1'b0, 1'b1, "wrap_pop");
        chk("wrap.order", int'(rd_data), 8'h10 + i);
      end
    end

    // Flush with a concurrent write after five pushes.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_flush");
    step(1'b1, 8'hEE, 1'b1, 1'b0, "flush_wr");
    chk("flush.count", int'(fill_count), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, "flush_pop");
    chk("flush.discarded", int'(underflow), 1);

    // Random traffic, biased phases so both full and empty get visited.
    for (int i = 0; i < 1500; i++) begin
      int wp, rp;
      wp = (i % 300 < 150) ? 70 : 30;
      rp = (i % 300 < 150) ? 30 : 70;
      step(($urandom_range(99) < wp), 8'($urandom), ($urandom_range(199) == 0),
           ($urandom_range(99) < rp), "rand");
    end

    // Async reset mid-push: outputs must clear before any clock edge.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b1, "pre_rst");
    step(1'b1, 8'h5A, 1'b0, 1'b0, "pre_rst2");
    write_req = 1'b1; din = 8'hA5;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("async_rst");
    write_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
